// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_stage
// Description : PC owner, instruction fetch and IF/ID register with
//               immediate-select pre-decode for the immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INS      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_ins,
    output logic [2:0]  id_imm_sel,
    output logic        id_illegal
);

    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_FENCE = 7'b0001111;
    localparam logic [6:0] c_OP_SYS   = 7'b1110011;

    localparam logic [2:0] c_SEL_I     = 3'b000;
    localparam logic [2:0] c_SEL_SHAMT = 3'b001;
    localparam logic [2:0] c_SEL_IU    = 3'b010;
    localparam logic [2:0] c_SEL_S     = 3'b011;
    localparam logic [2:0] c_SEL_B     = 3'b100;
    localparam logic [2:0] c_SEL_NONE  = 3'b111;

    // Returns {illegal, imm_sel}; unrecognised encodings fall to NONE + illegal.
    function automatic logic [3:0] f_decode(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] res;
        op  = ins[6:0];
        f3  = ins[14:12];
        res = {1'b1, c_SEL_NONE};
        case (op)
            c_OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    res = {1'b0, c_SEL_SHAMT};
                else if (f3 == 3'b011)
                    res = {1'b0, c_SEL_IU};
                else
                    res = {1'b0, c_SEL_I};
            end
            c_OP_LOAD:  res = {1'b0, c_SEL_I};
            c_OP_JALR:  res = (f3 == 3'b000) ? {1'b0, c_SEL_I} : {1'b1, c_SEL_NONE};
            c_OP_STORE: res = {1'b0, c_SEL_S};
            c_OP_BR:    res = (f3 == 3'b010 || f3 == 3'b011) ? {1'b1, c_SEL_NONE}
                                                             : {1'b0, c_SEL_B};
            c_OP_REG, c_OP_LUI, c_OP_AUIPC,
            c_OP_JAL, c_OP_FENCE, c_OP_SYS:
                        res = {1'b0, c_SEL_NONE};
            default:    res = {1'b1, c_SEL_NONE};
        endcase
        return res;
    endfunction

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_id_ins;
    logic [2:0]  r_id_imm_sel;
    logic        r_id_illegal;

    logic [3:0]  w_dec;
    logic [31:0] w_pc_plus4;
    logic        w_unused;

    always_comb begin
        w_dec      = f_decode(imem_rdata);
        w_pc_plus4 = r_pc + 32'd4;
    end

    // Redirect targets are word-aligned by construction; the low bits are dropped.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_id_valid    <= 1'b0;
            r_id_pc       <= 32'd0;
            r_id_pc_plus4 <= 32'd4;
            r_id_ins      <= NOP_INS;
            r_id_imm_sel  <= c_SEL_I;
            r_id_illegal  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= {redirect_pc[31:2], 2'b00};
            r_id_valid    <= 1'b0;
            r_id_ins      <= NOP_INS;
            r_id_imm_sel  <= c_SEL_I;
            r_id_illegal  <= 1'b0;
        end else if (!id_stall) begin
            if (imem_ready) begin
                r_pc          <= w_pc_plus4;
                r_id_valid    <= 1'b1;
                r_id_pc       <= r_pc;
                r_id_pc_plus4 <= w_pc_plus4;
                r_id_ins      <= imem_rdata;
                r_id_imm_sel  <= w_dec[2:0];
                r_id_illegal  <= w_dec[3];
            end else begin
                // Memory wait state: bubble, keep id_pc of the last real instruction.
                r_id_valid    <= 1'b0;
                r_id_ins      <= NOP_INS;
                r_id_imm_sel  <= c_SEL_I;
                r_id_illegal  <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = rst_n & ~id_stall;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_ins      = r_id_ins;
    assign id_imm_sel  = r_id_imm_sel;
    assign id_illegal  = r_id_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// Scoreboard bench for fetch_decode_stage: driver queues expected IF/ID state,
// monitor compares it one edge later.
module tb_fetch_decode_stage;

    localparam logic [31:0] c_RV  = 32'h0000_0100;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_ins;
    logic [2:0]  id_imm_sel;
    logic        id_illegal;

    fetch_decode_stage #(
        .RESET_VECTOR(c_RV),
        .NOP_INS     (c_NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .id_stall      (id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .id_ins        (id_ins),
        .id_imm_sel    (id_imm_sel),
        .id_illegal    (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] ins;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Expected IF/ID state tracked by the driver
    logic [31:0] m_pc, m_idpc, m_plus4, m_ins;
    logic        m_valid, m_ill;
    logic [2:0]  m_sel;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock of stimulus; esel/eill are the hand-decoded values for rdata.
    task automatic cyc(input logic rstn, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] rdata, input logic [2:0] esel,
                       input logic eill);
        exp_t e;
        @(negedge clk);
        rst_n          = rstn;
        id_stall       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        imem_rdata     = rdata;
        #1;
        chk("imem_req", {31'd0, imem_req}, {31'd0, rstn & ~st});
        if (!rstn) begin
            m_pc = c_RV; m_valid = 1'b0; m_idpc = 32'd0; m_plus4 = 32'd4;
            m_ins = c_NOP; m_sel = 3'b000; m_ill = 1'b0;
        end else if (rv) begin
            m_pc = {rpc[31:2], 2'b00};
            m_valid = 1'b0; m_ins = c_NOP; m_sel = 3'b000; m_ill = 1'b0;
        end else if (!st) begin
            if (rdy) begin
                m_idpc = m_pc; m_plus4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                m_valid = 1'b1; m_ins = rdata; m_sel = esel; m_ill = eill;
            end else begin
                m_valid = 1'b0; m_ins = c_NOP; m_sel = 3'b000; m_ill = 1'b0;
            end
        end
        e.addr = m_pc; e.valid = m_valid; e.pc = m_idpc; e.plus4 = m_plus4;
        e.ins = m_ins; e.sel = m_sel; e.ill = m_ill;
        q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] rdata, input logic [2:0] esel, input logic eill);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, rdata, esel, eill);
    endtask

    // Monitor: the DUT presents new IF/ID state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr",   imem_addr,   e.addr);
                chk("id_valid",    {31'd0, id_valid},   {31'd0, e.valid});
                chk("id_pc",       id_pc,       e.pc);
                chk("id_pc_plus4", id_pc_plus4, e.plus4);
                chk("id_ins",      id_ins,      e.ins);
                chk("id_imm_sel",  {29'd0, id_imm_sel}, {29'd0, e.sel});
                chk("id_illegal",  {31'd0, id_illegal}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;

        // Reset, including with other controls active
        cyc(1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 32'h1234_5678, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h1234_5678, 3'b000, 1'b0);

        // First fetch from the reset vector, then the imm_sel stream
        fetch(32'h0050_0093, 3'b000, 1'b0);   // addi
        fetch(32'h0020_9113, 3'b001, 1'b0);   // slli
        fetch(32'h0030_B193, 3'b010, 1'b0);   // sltiu
        fetch(32'h0011_2223, 3'b011, 1'b0);   // sw
        fetch(32'hFE00_0EE3, 3'b100, 1'b0);   // beq

        // Three-cycle stall; rdata on those cycles must not be captured
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
        fetch(32'h0010_0093, 3'b000, 1'b0);   // resumes at 0x114

        // Redirect beats stall; low target bits dropped
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
        fetch(32'h00A0_0113, 3'b000, 1'b0);   // from 0x200

        // Two memory wait states, then illegal and boundary decodes
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0011_2223, 3'b000, 1'b0);
        fetch(32'hFFFF_FFFF, 3'b111, 1'b1);
        fetch(32'h0000_00B7, 3'b111, 1'b0);   // lui: no immediate, legal
        fetch(32'h0000_1067, 3'b111, 1'b1);   // jalr f3=001
        fetch(32'h0000_2063, 3'b111, 1'b1);   // branch f3=010
        fetch(32'h0000_2083, 3'b000, 1'b0);   // lw
        fetch(32'h0050_D093, 3'b001, 1'b0);   // srli
        fetch(32'h0000_0092, 3'b111, 1'b1);   // ins[1:0]!=11

        // PC wrap at the top of the address space
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
        fetch(32'h0000_0013, 3'b000, 1'b0);   // id_pc_plus4 = 0
        fetch(32'h0000_0073, 3'b111, 1'b0);   // ecall from 0x0

        // Reset during a stall
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
        fetch(32'h0020_9113, 3'b001, 1'b0);

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register that sits directly upstream of the immediate generator. It owns the PC and presents fetch addresses to instruction memory. It latches each returned instruction together with its PC. It pre-decodes the 3-bit immediate-select code that the immediate generator consumes alongside the instruction word. It handles downstream stall, control-flow redirect (flush), and instruction-memory wait states.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INS, 32'h0000_0013, instruction injected into the ID register on bubbles and flushes (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
imem_addr  output  32  fetch address, equal to pc_q (combinational from register).
imem_req  output  1  fetch request: 1 when rst_n=1 and id_stall=0.
imem_rdata  input  32  instruction word for imem_addr, valid in the same cycle when imem_ready=1.
imem_ready  input  1  memory has valid imem_rdata this cycle; 0 = wait state.
id_stall  input  1  downstream cannot accept; hold PC and the ID register.
redirect_valid  input  1  taken branch/jump resolved downstream; flush and refetch.
redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 0).
id_valid  output  1  ID register holds a real instruction.
id_pc  output  32  PC of id_ins.
id_pc_plus4  output  32  id_pc + 4, mod 2^32.
id_ins  output  32  latched instruction word, feeds immediate generator ins.
id_imm_sel  output  3  pre-decoded immediate-select code, feeds immediate generator imm_sel.
id_illegal  output  1  id_ins is not a recognised RV32I encoding.

Behaviour:
Reset (rst_n=0 at a clock edge), regardless of other inputs:
- pc_q=RESET_VECTOR, id_valid=0, id_pc=0, id_pc_plus4=4.
- id_ins=NOP_INS, id_imm_sel=3'b000, id_illegal=0.
- imem_req=0 while rst_n=0.
- Reset mid-stall or mid-redirect discards all pending state.

Per-cycle update priority: reset > redirect > stall > fetch.
- Redirect (redirect_valid=1): pc_q<={redirect_pc[31:2],2'b00}; id_valid<=0; id_ins<=NOP_INS; id_imm_sel<=000; id_illegal<=0. Redirect overrides id_stall in the same cycle. imem_rdata in this cycle is discarded.
- Stall (id_stall=1, no redirect): pc_q and all id_* registers hold. imem_req=0.
- Fetch, imem_ready=1:
  - pc_q<=pc_q+4 (wraps 32'hFFFF_FFFC -> 0).
  - id_valid<=1; id_ins<=imem_rdata; id_pc<=pc_q; id_pc_plus4<=pc_q+4.
  - id_imm_sel and id_illegal <= decode(imem_rdata).
- Fetch, imem_ready=0: pc_q holds; insert bubble (id_valid<=0, id_ins<=NOP_INS, id_imm_sel<=000, id_illegal<=0); id_pc/id_pc_plus4 hold.

Latency: an instruction at pc_q accepted in cycle t appears on id_* in cycle t+1. Throughput is 1 instruction/cycle with no stalls or wait states.

decode() (op=ins[6:0], f3=ins[14:12]):
- op 0010011 (OP-IMM): f3=001 or 101 -> 001 (shamt); f3=011 -> 010 (sltiu unsigned); other f3 -> 000.
- op 0000011 (load) -> 000; op 1100111 (jalr, f3=000) -> 000.
- op 0100011 (store) -> 011; op 1100011 (branch) -> 100.
- op 0110011, 0110111, 0010111, 1101111, 0001111, 1110011 -> 111 (immediate generator outputs 0).
- Any other op, ins[1:0]!=2'b11, jalr with f3!=000, or branch f3 in {010,011} -> 111 with id_illegal=1.
- id_illegal is meaningful only when id_valid=1.

Width rules: all PC arithmetic is unsigned 32-bit, modulo 2^32. No misalignment exception is raised (bits [1:0] are forced 0).

Test Plan:
- Reset with RESET_VECTOR=0x100, then release with imem_ready=1 feeding 0x00500093 (addi x1,x0,5) -> imem_addr=0x100; next cycle id_valid=1, id_pc=0x100, id_ins=0x00500093, id_imm_sel=000, pc_q=0x104.
- Stream 0x00209113 (slli), 0x0030B193 (sltiu), 0x00112223 (sw), 0xFE000EE3 (beq) -> id_imm_sel sequence 001, 010, 011, 100 on consecutive cycles; id_illegal=0 throughout.
- Assert id_stall for 3 cycles mid-stream -> id_* and imem_addr frozen, imem_req=0; fetch resumes at the same address with no lost or duplicated instruction.
- Assert redirect_valid with redirect_pc=0x203 and id_stall=1 in the same cycle -> next cycle id_valid=0, id_ins=0x00000013, imem_addr=0x200; the following cycle shows the instruction from 0x200.
- imem_ready=0 for 2 cycles -> two bubbles (id_valid=0, id_ins=NOP_INS), pc_q unchanged; feed 0xFFFFFFFF -> id_illegal=1, id_imm_sel=111.
- Start with pc_q=0xFFFFFFFC and fetch -> id_pc_plus4=0x0, next imem_addr=0x0; assert rst_n=0 during a stall -> all outputs return to reset values next edge.
